// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide side unit for the EX stage.
// One result bit per cycle (radix-2 shift-add / restoring divide), operands
// held as magnitudes with a sign fixup on the last iteration. Divide special
// cases (x/0, MIN/-1) can optionally complete in a single cycle.
module rv_muldiv_unit #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [4:0]      rd_i,
  input  logic            kill_i,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o,
  output logic            busy_o,
  output logic [1:0]      dbg_state_o
);

  // Handshake: a request transfers on a rising edge where valid_i & ready_o
  // & ~kill_i; ready_o depends only on state, and valid_o is a single-cycle
  // strobe with no back-pressure (the consumer must take it that cycle).

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_d;

  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  logic [XLEN-1:0] acc_hi;   // product high half / partial remainder
  logic [XLEN-1:0] acc_lo;   // multiplier bits / dividend bits -> quotient
  logic [XLEN-1:0] opb;      // multiplicand or divisor magnitude
  logic            neg_res_q; // negate product or quotient at the end
  logic            neg_a_q;   // remainder takes the dividend's sign

  // Request decode and operand magnitudes
  logic            accept, is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic            b_zero, ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  assign ready_o     = (state != S_CALC);
  assign valid_o     = (state == S_DONE);
  assign accept      = valid_i & ready_o & ~kill_i;
  assign busy_o      = (state == S_CALC) | accept;
  assign dbg_state_o = state;

  assign is_div  = funct3_i[2];
  assign a_sgn   = (funct3_i == 3'd1) | (funct3_i == 3'd2) |
                   (funct3_i == 3'd4) | (funct3_i == 3'd6);
  assign b_sgn   = (funct3_i == 3'd1) | (funct3_i == 3'd4) | (funct3_i == 3'd6);
  assign a_neg   = a_sgn & a_i[XLEN-1];
  assign b_neg   = b_sgn & b_i[XLEN-1];
  assign a_mag   = a_neg ? -a_i : a_i;
  assign b_mag   = b_neg ? -b_i : b_i;
  assign b_zero  = (b_i == '0);
  assign ovf     = is_div & ~funct3_i[0] & (a_i == {1'b1, {(XLEN-1){1'b0}}}) &
                   (b_i == '1);
  assign special = EARLY_OUT && is_div && (b_zero || ovf);
  // x/0: quotient all ones, remainder a. MIN/-1: quotient MIN (= a), remainder 0.
  assign special_res = b_zero ? (funct3_i[1] ? a_i : '1)
                              : (funct3_i[1] ? '0  : a_i);

  // One iteration step for each datapath
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [XLEN-1:0]   mul_hi_nx, mul_lo_nx, div_hi_nx, div_lo_nx;
  logic              fits;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   q_fix, r_fix;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
  assign mul_hi_nx = mul_sum[XLEN:1];
  assign mul_lo_nx = {mul_sum[0], acc_lo[XLEN-1:1]};

  assign div_shift = {acc_hi, acc_lo[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opb};
  assign fits      = ~div_diff[XLEN];
  assign div_hi_nx = fits ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
  assign div_lo_nx = {acc_lo[XLEN-2:0], fits};

  assign prod     = {mul_hi_nx, mul_lo_nx};
  assign prod_fix = neg_res_q ? -prod : prod;
  assign q_fix    = neg_res_q ? -div_lo_nx : div_lo_nx;
  assign r_fix    = neg_a_q ? -div_hi_nx : div_hi_nx;

  // Select the signed-corrected result on the final iteration
  logic [XLEN-1:0] final_res;
  always_comb begin
    final_res = r_fix;
    case (op_q)
      3'd0:                final_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    final_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:          final_res = q_fix;
      default:             final_res = r_fix;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next-state logic; a kill overrides everything
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (accept) state_d = special ? S_DONE : S_CALC;
      S_CALC:  if (cnt == LAST) state_d = S_DONE;
      S_DONE:  state_d = accept ? (special ? S_DONE : S_CALC) : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (kill_i) state_d = S_IDLE;
  end

  // Operand capture, iteration and result register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= '0;
      op_q      <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      opb       <= '0;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
      result_o  <= '0;
      rd_o      <= '0;
    end else if (accept) begin
      cnt       <= '0;
      op_q      <= funct3_i;
      rd_o      <= rd_i;
      acc_hi    <= '0;
      acc_lo    <= is_div ? a_mag : b_mag;
      opb       <= is_div ? b_mag : a_mag;
      // x/0 quotient stays all ones regardless of operand signs
      neg_res_q <= (a_neg ^ b_neg) & ~(is_div & b_zero);
      neg_a_q   <= a_neg;
      if (special) result_o <= special_res;
    end else if (kill_i) begin
      cnt <= '0;
    end else if (state == S_CALC) begin
      acc_hi <= op_q[2] ? div_hi_nx : mul_hi_nx;
      acc_lo <= op_q[2] ? div_lo_nx : mul_lo_nx;
      if (cnt == LAST) begin
        cnt      <= '0;
        result_o <= final_res;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Bench for rv_muldiv_unit: three instances (32-bit early-out, 32-bit full
// iteration, 64-bit early-out), directed vector table, multi-cycle corner
// sequences and randomized ops against an arithmetic reference model.
module tb_rv_muldiv_unit;

  logic        clk, rstn;
  logic [2:0]  v_in, k_in, vo, rdy, bsy;
  logic [2:0]  f_in [3];
  logic [63:0] a_in [3];
  logic [63:0] b_in [3];
  logic [4:0]  rd_in [3];
  logic [4:0]  rdo [3];
  logic [1:0]  st [3];
  logic [31:0] r0, r1;
  logic [63:0] r2;

  int tests = 0;
  int fails = 0;

  rv_muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b1)) u_eo (
    .clk(clk), .rstn(rstn), .valid_i(v_in[0]), .ready_o(rdy[0]),
    .funct3_i(f_in[0]), .a_i(a_in[0][31:0]), .b_i(b_in[0][31:0]),
    .rd_i(rd_in[0]), .kill_i(k_in[0]), .valid_o(vo[0]), .result_o(r0),
    .rd_o(rdo[0]), .busy_o(bsy[0]), .dbg_state_o(st[0]));

  rv_muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b0)) u_full (
    .clk(clk), .rstn(rstn), .valid_i(v_in[1]), .ready_o(rdy[1]),
    .funct3_i(f_in[1]), .a_i(a_in[1][31:0]), .b_i(b_in[1][31:0]),
    .rd_i(rd_in[1]), .kill_i(k_in[1]), .valid_o(vo[1]), .result_o(r1),
    .rd_o(rdo[1]), .busy_o(bsy[1]), .dbg_state_o(st[1]));

  rv_muldiv_unit #(.XLEN(64), .EARLY_OUT(1'b1)) u_64 (
    .clk(clk), .rstn(rstn), .valid_i(v_in[2]), .ready_o(rdy[2]),
    .funct3_i(f_in[2]), .a_i(a_in[2]), .b_i(b_in[2]),
    .rd_i(rd_in[2]), .kill_i(k_in[2]), .valid_o(vo[2]), .result_o(r2),
    .rd_o(rdo[2]), .busy_o(bsy[2]), .dbg_state_o(st[2]));

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] get_res(input int u);
    if (u == 0) return {32'b0, r0};
    if (u == 1) return {32'b0, r1};
    return r2;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: exact RISC-V M semantics via wide signed arithmetic
  function automatic logic signed [127:0] ext(input logic [63:0] x, input bit s, input int xl);
    if (xl == 64) return s ? {{64{x[63]}}, x} : {64'b0, x};
    return s ? {{96{x[31]}}, x[31:0]} : {96'b0, x[31:0]};
  endfunction

  function automatic logic [63:0] ref_res(input logic [2:0] f, input logic [63:0] a,
                                          input logic [63:0] b, input int xl);
    logic signed [127:0] sa, sb, p, q, r;
    logic [63:0] mask, minv;
    bit a_s, b_s;
    mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    minv = (xl == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    a_s  = (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd6);
    b_s  = (f == 3'd1) || (f == 3'd4) || (f == 3'd6);
    sa   = ext(a, a_s, xl);
    sb   = ext(b, b_s, xl);
    if (f == 3'd0) begin
      p = sa * sb;
      return p[63:0] & mask;
    end
    if (f < 3'd4) begin
      p = sa * sb;
      return (xl == 64) ? p[127:64] : {32'b0, p[63:32]};
    end
    if ((b & mask) == 64'd0) return f[1] ? (a & mask) : mask;
    if ((f == 3'd4 || f == 3'd6) && (a & mask) == minv && (b & mask) == mask)
      return (f == 3'd4) ? minv : 64'd0;
    q = sa / sb;
    r = sa % sb;
    return (f[1] ? r[63:0] : q[63:0]) & mask;
  endfunction

  function automatic logic [63:0] rnd_opnd(input int xl);
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = 64'hFFFF_FFFF_FFFF_FFFF;
      2: v = (xl == 64) ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
      3: v = 64'($urandom_range(0, 20));
      default: v = {$urandom, $urandom};
    endcase
    return (xl == 64) ? v : (v & 64'hFFFF_FFFF);
  endfunction

  // Driver: present one op at the current negedge, wait for its strobe
  task automatic run_op(input int u, input logic [2:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd,
                        output logic [63:0] res, output logic [4:0] rdv,
                        output int lat, output bit rdy_ok);
    v_in[u] = 1'b1; f_in[u] = f; a_in[u] = a; b_in[u] = b; rd_in[u] = rd;
    @(negedge clk);
    v_in[u] = 1'b0;
    lat = 1;
    rdy_ok = 1'b1;
    while (!vo[u] && lat < 200) begin
      if (rdy[u]) rdy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    res = get_res(u);
    rdv = rdo[u];
  endtask

  typedef struct {
    int          u;
    logic [2:0]  f;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl [21];

  initial begin
    logic [63:0] res, exp;
    logic [4:0]  rdv, rd;
    logic [2:0]  f;
    logic [63:0] a, b;
    int          lat, n, xl, elat;
    bit          rok, seen, busy_ok, special;

    tbl[0]  = '{0, 3'd0, 64'h7,        64'hFFFF_FFFD, 64'hFFFF_FFEB, 33};
    tbl[1]  = '{0, 3'd1, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 33};
    tbl[2]  = '{0, 3'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 33};
    tbl[3]  = '{0, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 33};
    tbl[4]  = '{0, 3'd4, 64'hFFFF_FFF9, 64'h2,        64'hFFFF_FFFD, 33};
    tbl[5]  = '{0, 3'd6, 64'hFFFF_FFF9, 64'h2,        64'hFFFF_FFFF, 33};
    tbl[6]  = '{0, 3'd5, 64'hFFFF_FFFF, 64'h10,       64'h0FFF_FFFF, 33};
    tbl[7]  = '{0, 3'd7, 64'hFFFF_FFFF, 64'h10,       64'hF,         33};
    tbl[8]  = '{0, 3'd4, 64'h1234,      64'h0,        64'hFFFF_FFFF, 1};
    tbl[9]  = '{0, 3'd7, 64'h5,         64'h0,        64'h5,         1};
    tbl[10] = '{0, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1};
    tbl[11] = '{0, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0,         1};
    tbl[12] = '{1, 3'd4, 64'h1234,      64'h0,        64'hFFFF_FFFF, 33};
    tbl[13] = '{1, 3'd7, 64'h5,         64'h0,        64'h5,         33};
    tbl[14] = '{1, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 33};
    tbl[15] = '{1, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0,         33};
    tbl[16] = '{1, 3'd6, 64'hFFFF_FFF9, 64'h0,        64'hFFFF_FFF9, 33};
    tbl[17] = '{1, 3'd4, 64'hFFFF_FFF9, 64'h0,        64'hFFFF_FFFF, 33};
    tbl[18] = '{2, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFE, 65};
    tbl[19] = '{2, 3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                64'h4000_0000_0000_0000, 65};
    tbl[20] = '{2, 3'd0, 64'h7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};

    // Reset
    rstn = 1'b0;
    v_in = '0;
    k_in = '0;
    for (int u = 0; u < 3; u++) begin
      f_in[u] = '0; a_in[u] = '0; b_in[u] = '0; rd_in[u] = '0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check($sformatf("reset_valid u%0d", u), 64'(vo[u]), 64'd0);
      check($sformatf("reset_ready u%0d", u), 64'(rdy[u]), 64'd1);
      check($sformatf("reset_busy u%0d", u), 64'(bsy[u]), 64'd0);
      check($sformatf("reset_result u%0d", u), get_res(u), 64'd0);
      check($sformatf("reset_rd u%0d", u), 64'(rdo[u]), 64'd0);
    end
    rstn = 1'b1;
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 21; i++) begin
      rd = 5'(i + 1);
      run_op(tbl[i].u, tbl[i].f, tbl[i].a, tbl[i].b, rd, res, rdv, lat, rok);
      check($sformatf("vec%0d result", i), res, tbl[i].exp);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(tbl[i].lat));
      check($sformatf("vec%0d rd", i), 64'(rdv), 64'(rd));
      check($sformatf("vec%0d ready_low", i), 64'(rok), 64'd1);
    end

    // Kill mid-divide at T+10, new MUL accepted at T+11
    v_in[0] = 1'b1; f_in[0] = 3'd4; a_in[0] = 64'd1000; b_in[0] = 64'd3; rd_in[0] = 5'd9;
    @(negedge clk);
    v_in[0] = 1'b0;
    n = 1;
    seen = 1'b0;
    while (n < 10) begin
      if (vo[0]) seen = 1'b1;
      @(negedge clk);
      n++;
    end
    k_in[0] = 1'b1;
    @(negedge clk);
    k_in[0] = 1'b0;
    if (vo[0]) seen = 1'b1;
    check("kill ready", 64'(rdy[0]), 64'd1);
    run_op(0, 3'd0, 64'd3, 64'd4, 5'd10, res, rdv, lat, rok);
    check("kill no_valid", 64'(seen), 64'd0);
    check("after_kill mul result", res, 64'd12);
    check("after_kill mul latency", 64'(lat), 64'd33);

    // Kill and request in the same cycle: nothing accepted
    v_in[0] = 1'b1; k_in[0] = 1'b1; f_in[0] = 3'd0; a_in[0] = 64'd2; b_in[0] = 64'd2;
    #1;
    check("kill_accept busy", 64'(bsy[0]), 64'd0);
    @(negedge clk);
    v_in[0] = 1'b0; k_in[0] = 1'b0;
    check("kill_accept ready", 64'(rdy[0]), 64'd1);
    check("kill_accept valid", 64'(vo[0]), 64'd0);

    // Back-to-back: second request held during DONE of the first
    v_in[0] = 1'b1; f_in[0] = 3'd0; a_in[0] = 64'd5; b_in[0] = 64'd6; rd_in[0] = 5'd3;
    @(negedge clk);
    v_in[0] = 1'b0;
    n = 1;
    busy_ok = 1'b1;
    while (!vo[0] && n < 200) begin
      if (!bsy[0]) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check("b2b first result", {32'b0, r0}, 64'd30);
    v_in[0] = 1'b1; f_in[0] = 3'd5; a_in[0] = 64'd100; b_in[0] = 64'd7; rd_in[0] = 5'd4;
    #1;
    if (!bsy[0]) busy_ok = 1'b0;
    @(negedge clk);
    v_in[0] = 1'b0;
    n = 1;
    while (!vo[0] && n < 200) begin
      if (!bsy[0]) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check("b2b second result", {32'b0, r0}, 64'd14);
    check("b2b second latency", 64'(n), 64'd33);
    check("b2b second rd", 64'(rdo[0]), 64'd4);
    check("b2b busy_held", 64'(busy_ok), 64'd1);

    // Kill in the DONE cycle: strobe still visible that cycle
    run_op(0, 3'd0, 64'd2, 64'd9, 5'd12, res, rdv, lat, rok);
    check("kill_done result", res, 64'd18);
    k_in[0] = 1'b1;
    #1;
    check("kill_done valid", 64'(vo[0]), 64'd1);
    @(negedge clk);
    k_in[0] = 1'b0;
    check("kill_done next_valid", 64'(vo[0]), 64'd0);
    check("kill_done ready", 64'(rdy[0]), 64'd1);
    check("kill_done result_held", {32'b0, r0}, 64'd18);

    // Randomized ops against the reference model
    for (int u = 0; u < 3; u++) begin
      xl = (u == 2) ? 64 : 32;
      for (int i = 0; i < ((u == 2) ? 30 : 150); i++) begin
        f  = 3'($urandom_range(0, 7));
        a  = rnd_opnd(xl);
        b  = rnd_opnd(xl);
        rd = 5'($urandom_range(0, 31));
        exp = ref_res(f, a, b, xl);
        special = f[2] && ((ref_res(3'd5, 64'd0, b, xl) != 64'd0 && b == 64'd0) ||
                  ((f == 3'd4 || f == 3'd6) && a == ((xl == 64) ? 64'h8000_0000_0000_0000
                  : 64'h8000_0000) && b == ((xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                  : 64'hFFFF_FFFF)));
        elat = (u != 1 && special) ? 1 : xl + 1;
        run_op(u, f, a, b, rd, res, rdv, lat, rok);
        check($sformatf("rand u%0d f%0d a=%h b=%h result", u, f, a, b), res, exp);
        check($sformatf("rand u%0d f%0d latency", u, f), 64'(lat), 64'(elat));
        check($sformatf("rand u%0d rd", u), 64'(rdv), 64'(rd));
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
    end

    // Asynchronous reset mid-operation
    v_in[0] = 1'b1; f_in[0] = 3'd0; a_in[0] = 64'd11; b_in[0] = 64'd13; rd_in[0] = 5'd21;
    @(negedge clk);
    v_in[0] = 1'b0;
    repeat (5) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("async_reset ready", 64'(rdy[0]), 64'd1);
    check("async_reset valid", 64'(vo[0]), 64'd0);
    check("async_reset busy", 64'(bsy[0]), 64'd0);
    check("async_reset rd", 64'(rdo[0]), 64'd0);
    @(negedge clk);
    check("async_reset result", {32'b0, r0}, 64'd0);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (vo[0]) seen = 1'b1;
    end
    check("async_reset no_valid", 64'(seen), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv_muldiv_unit.md
# rv_muldiv_unit

Parametrised iterative RV32M/RV64M multiply-divide unit. It executes all eight M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) as a multi-cycle side unit next to the EX-stage ALU. `busy_o` feeds the hazard unit, which freezes IF/ID/EX while an operation is in flight. The result returns with its destination register for the EX/MEM pipeline register.

## Interface
Parameters:
- `XLEN`, default 32: operand/result width; legal values 32 and 64.
- `EARLY_OUT`, default 1: 1 enables one-cycle completion for the divide special cases; 0 runs the full iteration for every operation.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  operation request.
- `ready_o`  out  1  unit can accept this cycle (combinational from state).
- `funct3_i`  in  3  RV M-encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `a_i`  in  XLEN  rs1 operand.
- `b_i`  in  XLEN  rs2 operand.
- `rd_i`  in  5  destination register tag.
- `kill_i`  in  1  flush from trap/branch; aborts any in-flight operation.
- `valid_o`  out  1  one-cycle result strobe.
- `result_o`  out  XLEN  result; held stable until the next completion.
- `rd_o`  out  5  tag captured at accept.
- `busy_o`  out  1  high in CALC, or when a request is presented in IDLE/DONE and accepted this cycle.

## Operation
- Accept condition: `valid_i & ready_o & ~kill_i`. The accept edge captures operands, funct3, and tag.
- States:
  - IDLE: `ready_o`=1. Accept goes to CALC; a special case with `EARLY_OUT`=1 goes to DONE.
  - CALC: `ready_o`=0. One bit per cycle; 5/6-bit counter `cnt` counts 0..XLEN-1. At `cnt`==XLEN-1, sign fixup is applied, `result_o` is registered, and the state goes to DONE.
  - DONE: `valid_o`=1, `ready_o`=1. Accept goes to CALC (back-to-back); otherwise the state goes to IDLE.
- Signed handling: operands are converted to magnitudes at accept according to funct3 (MULHSU treats only `a` as signed).
- Multiply: radix-2 shift-add into a 2·XLEN accumulator. If signs differ, the 2·XLEN product is two's-complement negated. MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits.
- Divide: restoring, quotient and remainder in XLEN-bit registers.
  - Quotient is negated if operand signs differ (DIV).
  - Remainder takes the sign of the dividend (REM).
- Special cases (exact RISC-V semantics):
  - b=0: DIV/DIVU give all-ones, REM/REMU give `a`.
  - Signed `a`=MIN and `b`=-1: DIV gives MIN, REM gives 0.
  - With `EARLY_OUT`=0 the same values result after the full iteration.
- `kill_i` high at any edge: next state is IDLE, `cnt` is cleared, and no `valid_o` is produced for the aborted operation. `result_o` and `rd_o` keep their old values.
- `valid_i` with funct3 is ignored when `ready_o`=0 (no queuing).

## Timing
- Reset values: state IDLE, `valid_o`=0, `result_o`=0, `rd_o`=0, `cnt`=0, `busy_o`=0, `ready_o`=1.
- Reset asserted mid-operation returns to IDLE immediately (asynchronous); no completion is produced.
- Normal latency: accept in cycle T gives `valid_o` in cycle T+XLEN+1 (T+33 for XLEN=32).
- Early-out latency: `valid_o` in cycle T+1.
- Throughput: one operation per XLEN+1 cycles; accept in DONE overlaps the strobe with the next start.
- `kill_i` and accept in the same cycle: kill wins, nothing is accepted.
- `kill_i` in the DONE cycle: `valid_o` is still asserted that cycle. The consumer gates it with its own flush.

## Test plan
- Reset, then MUL a=7, b=-3 (0xFFFFFFFD) in cycle T: `valid_o` at T+33, result 0xFFFFFFEB, `rd_o` as given. `ready_o`=0 from T+1 to T+32.
- MULH a=0x80000000, b=0x80000000 gives 0x40000000. MULHSU a=-1, b=0xFFFFFFFF gives 0xFFFFFFFF. MULHU on the same operands gives 0xFFFFFFFE.
- DIV -7/2 gives 0xFFFFFFFD. REM -7/2 gives 0xFFFFFFFF. DIVU 0xFFFFFFFF/16 gives 0x0FFFFFFF. REMU 0xFFFFFFFF/16 gives 0xF.
- `EARLY_OUT`=1:
  - DIV x/0 gives 0xFFFFFFFF at T+1.
  - REMU 5/0 gives 5.
  - DIV 0x80000000/-1 gives 0x80000000.
  - REM 0x80000000/-1 gives 0.
  - With `EARLY_OUT`=0, all four complete at T+33 with identical values.
- Start DIV, assert `kill_i` at T+10:
  - `ready_o`=1 at T+11, and no `valid_o` ever appears for that operation.
  - A new MUL 3×4 accepted at T+11 gives 12 at T+44.
- Back-to-back: second request held on `valid_i` during DONE of the first is accepted that cycle. Its result arrives 33 cycles later, and `busy_o` never drops between the two operations.
- XLEN=64: MULHU 0xFFFF…F×0xFFFF…F gives 0xFFFF…FE at T+65.
